pha_peak_detect: RTL and testbench
==================================

# pha_peak_detect

Pulse-height analysis stage that consumes the offset-corrected 10-bit ADC sample stream (125 MHz system clock, one sample every other cycle) and produces one peak-height word per detected pulse. It applies an 8-sample moving average, a programmable lower-level discriminator, rise/fall peak tracking and a resolving-time hold-off. Its output feeds the waveform-memory writer through a valid/ready handshake, and it drops and counts events the writer cannot accept.

## Interface
- HOLDOFF, 625, resolving time in samples after each emitted peak (10 us at 62.5 MS/s)
- RISE_MAX, 255, maximum samples spent in RISE before a forced emit
- THR_INIT, 32, threshold value after reset (unsigned, 0..511)

- CLK  in  1  system clock, 125 MHz
- RSTN  in  1  reset, asynchronous, active-low
- SMPL  in  1  sample strobe, one cycle per ADC sample
- ADC  in  10  offset-corrected sample, two's complement
- ARM  in  1  measurement enable (USB mode 7)
- THR_UP32, THR_DN32, THR_UP4, THR_DN4  in  1 each  single-cycle threshold adjust pulses
- PEAK_RDY  in  1  downstream ready
- PEAK  out  10  peak height (unsigned; bit 9 always 0)
- PEAK_VLD  out  1  peak word valid
- THR  out  10  current threshold
- BUSY  out  1  high in RISE or HOLD (LED indicator)
- EVCNT  out  16  accepted events, wraps at 65535 -> 0
- DROPCNT  out  8  dropped events, saturates at 255

## Operation
- Clamp: s = ADC[9] ? 0 : ADC[8:0] (9-bit).
- Average: 8-deep history of s. 12-bit running sum = sum + s_new - s_oldest, updated on SMPL. avg = sum[11:3].
- History and sum clear to 0 on reset and on the ARM rising edge. The average therefore ramps in over the first 8 samples.
- The FSM evaluates on sd (SMPL delayed one cycle), using the updated avg.
  - IDLE: ARM=0. When ARM=1, go to WAIT.
  - WAIT: on sd, if avg > THR (strict), go to RISE, set pk = avg, set rise counter to 1.
  - RISE: on sd:
    - if avg > pk, set pk = avg.
    - if avg < pk, or avg <= THR, or rise counter = RISE_MAX: emit pk and go to HOLD with hold counter = HOLDOFF.
    - an equal avg keeps the FSM in RISE.
  - HOLD: on sd, decrement the counter. When the counter is 0 and avg <= THR, go to WAIT. If avg is still above THR at 0, stay in HOLD (pile-up guard).
  - ARM=0 in any state forces IDLE on the next cycle. A pending PEAK_VLD still completes its handshake.
- Emit:
  - If PEAK_VLD=0, or PEAK_VLD&PEAK_RDY in the same cycle: load PEAK = {0, pk}, set PEAK_VLD = 1, increment EVCNT.
  - Otherwise the event is dropped and DROPCNT increments (saturating).
- Handshake: PEAK_VLD stays high and PEAK stays stable until the first cycle with PEAK_RDY=1, inclusive. PEAK_VLD clears the cycle after, unless a new emit reloads it in that same cycle.
- Threshold:
  - One adjust per cycle, priority UP32 > DN32 > UP4 > DN4.
  - Result saturates to 0..511.
  - A new threshold is used from the next sd evaluation.

## Timing
- Reset values: PEAK=0, PEAK_VLD=0, THR=THR_INIT, BUSY=0, EVCNT=0, DROPCNT=0, FSM=IDLE, history=0.
- Latency:
  - SMPL in cycle t updates the sum at the end of t.
  - The FSM decides in cycle t+1.
  - PEAK_VLD is high from t+2.
- BUSY follows the FSM state with one cycle of register delay.
- RSTN asserted mid-pulse clears everything immediately (asynchronous). The first decision after release needs a fresh ARM rise.

## Configuration
- PHA_DROP_CNT_EN:
  - Defined: DROPCNT counts as specified.
  - Undefined: the drop counter logic is removed and DROPCNT is tied to 0. Dropping behaviour is otherwise identical.

## Test plan
- Basic pulse: THR=32, ARM=1, 8 samples of 0, 16 samples of 100, then 0. Required:
  - avg ramps 12, 25, 37; RISE is entered on 37.
  - PEAK=100, PEAK_VLD asserted 2 cycles after the SMPL carrying the first avg of 87.
  - EVCNT=1.
- Hold-off: bench HOLDOFF=16. A second identical pulse starting 10 samples after the emit gives no event. A third pulse 30 samples after the emit gives EVCNT=2.
- Back-pressure: PEAK_RDY=0, two pulses (peaks 100 and 60) outside hold-off. Required:
  - PEAK stays 100, DROPCNT=1.
  - With PEAK_RDY=1 for one cycle, PEAK_VLD drops the next cycle.
  - With PHA_DROP_CNT_EN undefined, DROPCNT=0.
- Threshold:
  - 3 UP32 pulses give THR=128.
  - 20 further UP32 pulses give THR=511.
  - From 0, DN4 gives 0.
  - UP32 and DN4 in the same cycle give +32 only.
- Negative clamp: ADC=10'h3F0 (-16) constant gives avg=0 and no trigger at THR=0.
- Reset mid-RISE: RSTN low during RISE gives all outputs at reset values and THR=32. After release with ARM held at 1, no event until ARM toggles.

Source files
------------

// File: rtl/pha_peak_if.sv
// Peak-word handshake between the pulse-height detector and the waveform-memory writer.
interface pha_peak_if;
    logic [9:0] peak;
    logic       peak_vld;
    logic       peak_rdy;

    modport master (output peak, output peak_vld, input peak_rdy);
    modport slave  (input peak, input peak_vld, output peak_rdy);
endinterface

// File: rtl/pha_peak_detect.sv
// Pulse-height peak detector: 8-sample moving average, threshold, rise/fall peak tracking, hold-off.
// Optional macro PHA_DROP_CNT_EN enables the saturating dropped-event counter (tied to 0 otherwise).
module pha_peak_detect #(
    parameter int HOLDOFF  = 625,
    parameter int RISE_MAX = 255,
    parameter int THR_INIT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        smpl_i,
    input  logic [9:0]  adc_i,
    input  logic        arm_i,
    input  logic        thr_up32_i,
    input  logic        thr_dn32_i,
    input  logic        thr_up4_i,
    input  logic        thr_dn4_i,
    output logic [9:0]  thr_o,
    output logic        busy_o,
    output logic [15:0] evcnt_o,
    output logic [7:0]  dropcnt_o,
    pha_peak_if.master  peak_if
);
    localparam int HW = $clog2(HOLDOFF + 1);
    localparam int RW = $clog2(RISE_MAX + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);
    localparam logic [RW-1:0] RISE_LAST = RW'(RISE_MAX);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RISE = 2'd2, ST_HOLD = 2'd3} state_t;

    state_t        state_q, state_d;
    logic          arm_q, sd_q, busy_q, vld_q;
    logic [8:0]    hist_q [8];
    logic [2:0]    ptr_q;
    logic [11:0]   sum_q;
    logic [8:0]    pk_q, pk_d, pk_max_s, smp_s, avg_s;
    logic [RW-1:0] rise_cnt_q, rise_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [9:0]    thr_q, thr_d, peak_q;
    logic [15:0]   evcnt_q;
    logic          arm_rise_s, above_s, emit_s, drop_s;

    // arm_q resets high so that ARM held through reset does not count as a fresh rising edge
    assign arm_rise_s = arm_i & ~arm_q;
    assign smp_s      = adc_i[9] ? 9'd0 : adc_i[8:0];
    assign avg_s      = sum_q[11:3];
    assign above_s    = {1'b0, avg_s} > thr_q;
    assign pk_max_s   = (avg_s > pk_q) ? avg_s : pk_q;
    assign drop_s     = emit_s & vld_q & ~peak_if.peak_rdy;

    // ARM edge detector and one-cycle sample-strobe delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_q <= 1'b1;
            sd_q  <= 1'b0;
        end else begin
            arm_q <= arm_i;
            sd_q  <= smpl_i;
        end
    end

    // Moving-average history ring and running sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) hist_q[i] <= 9'd0;
            ptr_q <= 3'd0;
            sum_q <= 12'd0;
        end else if (arm_rise_s) begin
            for (int i = 0; i < 8; i++) hist_q[i] <= 9'd0;
            ptr_q <= 3'd0;
            sum_q <= 12'd0;
        end else if (smpl_i) begin
            hist_q[ptr_q] <= smp_s;
            sum_q         <= sum_q + {3'd0, smp_s} - {3'd0, hist_q[ptr_q]};
            ptr_q         <= ptr_q + 3'd1;
        end
    end

    // Threshold adjust with priority and saturation to 0..511
    always_comb begin
        thr_d = thr_q;
        if (thr_up32_i) begin
            thr_d = (thr_q > 10'd479) ? 10'd511 : thr_q + 10'd32;
        end else if (thr_dn32_i) begin
            thr_d = (thr_q < 10'd32) ? 10'd0 : thr_q - 10'd32;
        end else if (thr_up4_i) begin
            thr_d = (thr_q > 10'd507) ? 10'd511 : thr_q + 10'd4;
        end else if (thr_dn4_i) begin
            thr_d = (thr_q < 10'd4) ? 10'd0 : thr_q - 10'd4;
        end else begin
            thr_d = thr_q;
        end
    end

    // Detector next-state: decisions are taken on the delayed strobe so the updated average is used
    always_comb begin
        state_d    = state_q;
        pk_d       = pk_q;
        rise_cnt_d = rise_cnt_q;
        hold_cnt_d = hold_cnt_q;
        emit_s     = 1'b0;
        if (!arm_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm_rise_s) state_d = ST_WAIT;
                    else            state_d = ST_IDLE;
                end
                ST_WAIT: begin
                    if (sd_q && above_s) begin
                        state_d    = ST_RISE;
                        pk_d       = avg_s;
                        rise_cnt_d = RW'(1);
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_RISE: begin
                    if (sd_q) begin
                        pk_d = pk_max_s;
                        if ((avg_s < pk_q) || !above_s || (rise_cnt_q == RISE_LAST)) begin
                            emit_s     = 1'b1;
                            state_d    = ST_HOLD;
                            hold_cnt_d = HOLD_LOAD;
                        end else begin
                            rise_cnt_d = rise_cnt_q + RW'(1);
                        end
                    end else begin
                        state_d = ST_RISE;
                    end
                end
                ST_HOLD: begin
                    if (sd_q) begin
                        if (hold_cnt_q != '0)  hold_cnt_d = hold_cnt_q - HW'(1);
                        else if (!above_s)     state_d = ST_WAIT;
                        else                   state_d = ST_HOLD;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Detector state, tracking registers and threshold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pk_q       <= 9'd0;
            rise_cnt_q <= '0;
            hold_cnt_q <= '0;
            thr_q      <= 10'(THR_INIT);
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pk_q       <= pk_d;
            rise_cnt_q <= rise_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            thr_q      <= thr_d;
            busy_q     <= (state_q == ST_RISE) || (state_q == ST_HOLD);
        end
    end

    // Output word, handshake and accepted-event counter; emitted pk is the tracked maximum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q  <= 10'd0;
            vld_q   <= 1'b0;
            evcnt_q <= 16'd0;
        end else if (emit_s && (!vld_q || peak_if.peak_rdy)) begin
            peak_q  <= {1'b0, pk_max_s};
            vld_q   <= 1'b1;
            evcnt_q <= evcnt_q + 16'd1;
        end else if (vld_q && peak_if.peak_rdy) begin
            vld_q <= 1'b0;
        end
    end

`ifdef PHA_DROP_CNT_EN
    logic [7:0] dropcnt_q;

    // Saturating dropped-event counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          dropcnt_q <= 8'd0;
        else if (drop_s && dropcnt_q != 8'd255) dropcnt_q <= dropcnt_q + 8'd1;
    end

    assign dropcnt_o = dropcnt_q;
`else
    logic unused_drop_s;
    assign unused_drop_s = drop_s;
    assign dropcnt_o     = 8'd0;
`endif

    assign thr_o            = thr_q;
    assign busy_o           = busy_q;
    assign evcnt_o          = evcnt_q;
    assign peak_if.peak     = peak_q;
    assign peak_if.peak_vld = vld_q;
endmodule

// File: tb/tb_pha_peak_detect.sv
// Directed self-checking bench for pha_peak_detect (hold-off shortened to 16 samples).
module tb_pha_peak_detect;
`ifdef PHA_DROP_CNT_EN
    localparam int EXP_DROP = 1;
`else
    localparam int EXP_DROP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        smpl = 1'b0;
    logic [9:0]  adc = 10'd0;
    logic        arm = 1'b0;
    logic        up32 = 1'b0, dn32 = 1'b0, up4 = 1'b0, dn4 = 1'b0;
    logic        rdy = 1'b1;
    logic [9:0]  thr;
    logic        busy;
    logic [15:0] evcnt;
    logic [7:0]  dropcnt;
    int          total = 0;
    int          bad = 0;

    pha_peak_if pif ();
    assign pif.peak_rdy = rdy;

    pha_peak_detect #(.HOLDOFF(16)) dut (
        .clk(clk), .rst_n(rst_n), .smpl_i(smpl), .adc_i(adc), .arm_i(arm),
        .thr_up32_i(up32), .thr_dn32_i(dn32), .thr_up4_i(up4), .thr_dn4_i(dn4),
        .thr_o(thr), .busy_o(busy), .evcnt_o(evcnt), .dropcnt_o(dropcnt),
        .peak_if(pif.master)
    );

    always #4 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [9:0] v);
        @(negedge clk);
        smpl = 1'b1;
        adc  = v;
        @(negedge clk);
        smpl = 1'b0;
    endtask

    task automatic send_n(input logic [9:0] v, input int n);
        for (int i = 0; i < n; i++) send(v);
    endtask

    task automatic thr_pulse(input logic u32, input logic d32, input logic u4, input logic d4, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            up32 = u32; dn32 = d32; up4 = u4; dn4 = d4;
            @(negedge clk);
            up32 = 1'b0; dn32 = 1'b0; up4 = 1'b0; dn4 = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_peak", 32'(pif.peak), 32'd0);
        chk("rst_vld", 32'(pif.peak_vld), 32'd0);
        chk("rst_thr", 32'(thr), 32'd32);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_evcnt", 32'(evcnt), 32'd0);
        chk("rst_drop", 32'(dropcnt), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        arm = 1'b1;
        repeat (2) @(negedge clk);

        // basic pulse: averages 12, 25, 37 -> RISE on 37
        send_n(10'd0, 8);
        send_n(10'd100, 3);
        repeat (2) @(negedge clk);
        chk("rise_busy", 32'(busy), 32'd1);
        send_n(10'd100, 13);
        send(10'd0);
        chk("lat_early", 32'(pif.peak_vld), 32'd0);
        @(negedge clk);
        chk("lat_vld", 32'(pif.peak_vld), 32'd1);
        chk("basic_peak", 32'(pif.peak), 32'd100);
        chk("basic_evcnt", 32'(evcnt), 32'd1);

        // second pulse inside hold-off is suppressed
        send_n(10'd0, 9);
        send_n(10'd100, 16);
        send_n(10'd0, 30);
        chk("holdoff_evcnt", 32'(evcnt), 32'd1);
        chk("holdoff_busy", 32'(busy), 32'd0);
        send_n(10'd100, 16);
        send(10'd0);
        @(negedge clk);
        chk("third_evcnt", 32'(evcnt), 32'd2);
        chk("third_peak", 32'(pif.peak), 32'd100);
        send_n(10'd0, 30);

        // back-pressure: first accepted, second dropped
        rdy = 1'b0;
        send_n(10'd100, 16);
        send_n(10'd0, 31);
        chk("bp_evcnt1", 32'(evcnt), 32'd3);
        chk("bp_vld1", 32'(pif.peak_vld), 32'd1);
        send_n(10'd60, 16);
        send_n(10'd0, 30);
        chk("bp_peak", 32'(pif.peak), 32'd100);
        chk("bp_drop", 32'(dropcnt), 32'(EXP_DROP));
        chk("bp_evcnt2", 32'(evcnt), 32'd3);
        chk("bp_vld2", 32'(pif.peak_vld), 32'd1);
        @(negedge clk);
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b1;
        chk("bp_release", 32'(pif.peak_vld), 32'd0);

        // threshold adjust and saturation
        thr_pulse(1'b1, 1'b0, 1'b0, 1'b0, 3);
        chk("thr_128", 32'(thr), 32'd128);
        thr_pulse(1'b1, 1'b0, 1'b0, 1'b0, 20);
        chk("thr_sat_hi", 32'(thr), 32'd511);
        thr_pulse(1'b0, 1'b1, 1'b0, 1'b0, 16);
        chk("thr_sat_lo", 32'(thr), 32'd0);
        thr_pulse(1'b0, 1'b0, 1'b0, 1'b1, 1);
        chk("thr_dn4_0", 32'(thr), 32'd0);
        thr_pulse(1'b1, 1'b0, 1'b0, 1'b1, 1);
        chk("thr_prio", 32'(thr), 32'd32);
        thr_pulse(1'b0, 1'b0, 1'b1, 1'b0, 1);
        chk("thr_up4", 32'(thr), 32'd36);
        thr_pulse(1'b0, 1'b1, 1'b0, 1'b0, 1);
        thr_pulse(1'b0, 1'b0, 1'b0, 1'b1, 1);
        chk("thr_zero", 32'(thr), 32'd0);

        // negative samples clamp to zero: no trigger even at threshold 0
        send_n(10'h3F0, 16);
        send_n(10'd0, 2);
        chk("clamp_busy", 32'(busy), 32'd0);
        chk("clamp_evcnt", 32'(evcnt), 32'd3);

        // asynchronous reset during RISE
        thr_pulse(1'b1, 1'b0, 1'b0, 1'b0, 1);
        thr_pulse(1'b0, 1'b0, 1'b1, 1'b0, 1);
        send_n(10'd100, 5);
        repeat (2) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_peak", 32'(pif.peak), 32'd0);
        chk("ar_vld", 32'(pif.peak_vld), 32'd0);
        chk("ar_thr", 32'(thr), 32'd32);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_evcnt", 32'(evcnt), 32'd0);
        chk("ar_drop", 32'(dropcnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_n(10'd100, 16);
        send_n(10'd0, 30);
        chk("norearm_evcnt", 32'(evcnt), 32'd0);
        chk("norearm_busy", 32'(busy), 32'd0);
        arm = 1'b0;
        repeat (2) @(negedge clk);
        arm = 1'b1;
        repeat (2) @(negedge clk);
        send_n(10'd0, 8);
        send_n(10'd100, 16);
        send(10'd0);
        @(negedge clk);
        chk("rearm_evcnt", 32'(evcnt), 32'd1);
        chk("rearm_peak", 32'(pif.peak), 32'd100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
